seq_divider_64: RTL and testbench

//  Unsigned 64/64 restoring divider, one quotient bit per clock. Consumes the

---
 rtl/seq_divider_64.sv | 132 +++++++++++++
 tb/tb_seq_divider_64.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_64.sv
// seq_divider_64: unsigned restoring divider, one quotient bit per clock.
// It is paced by an external iteration counter. The divider holds the counter
// in reset (cnt_reset=1) except during RUN. The counter's 'reached' flag marks
// the end of the iteration window.
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   start              operation request, accepted only while ready=1
//   dividend, divisor  operands, sampled on the accepting edge
//   cnt_reached        'reached' flag from the iteration counter
//   cnt_reset          registered counter reset, low only in RUN
//   ready              high in IDLE
//   done               one-cycle pulse on entry to DONE
//   quotient/remainder results, held until the next accepted start
//   div_by_zero        set with done when the divisor was zero
module seq_divider_64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cnt_reached,
  output logic             cnt_reset,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   r_q, r_n;
  logic [WIDTH-1:0] q_q, q_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;
  logic             div_by_zero_n, cnt_reset_n, done_n;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and compare at full WIDTH+1 precision.
  logic [WIDTH:0]   trial, diff;
  logic             ge;
  assign trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign diff  = trial - {1'b0, d_q};
  assign ge    = (trial >= {1'b0, d_q});

  assign ready = (state == S_IDLE);

  // Next-state and datapath update.
  always_comb begin
    state_n       = state;
    r_n           = r_q;
    q_n           = q_q;
    d_n           = d_q;
    quotient_n    = quotient;
    remainder_n   = remainder;
    div_by_zero_n = div_by_zero;
    cnt_reset_n   = 1'b1;
    done_n        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          d_n = divisor;
          if (divisor == '0) begin
            // The result is known immediately, so the counter is never released.
            state_n       = S_DONE;
            quotient_n    = '1;
            remainder_n   = dividend;
            div_by_zero_n = 1'b1;
            done_n        = 1'b1;
          end else begin
            state_n     = S_RUN;
            cnt_reset_n = 1'b0;
            r_n         = '0;
            q_n         = dividend;
          end
        end
      end
      S_RUN: begin
        if (cnt_reached) begin
          state_n       = S_DONE;
          quotient_n    = q_q;
          remainder_n   = r_q[WIDTH-1:0];
          div_by_zero_n = 1'b0;
          done_n        = 1'b1;
        end else begin
          cnt_reset_n = 1'b0;
          q_n         = {q_q[WIDTH-2:0], ge};
          r_n         = ge ? diff : trial;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt_reset   <= 1'b1;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      r_q         <= r_n;
      q_q         <= q_n;
      d_q         <= d_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      div_by_zero <= div_by_zero_n;
      cnt_reset   <= cnt_reset_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_divider_64.sv
// Directed bench for seq_divider_64 with a behavioural iteration counter:
// the counter is held at 0 while cnt_reset=1 and counts up to a saturating
// 64 when released; reached is high at 64.
module tb_seq_divider_64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] dividend, divisor;
  logic        cnt_reached, cnt_reset, ready, done, div_by_zero;
  logic [63:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic [6:0] cnt = 7'd0;
  always @(posedge clk) begin
    if (cnt_reset) cnt <= 7'd0;
    else if (cnt != 7'd64) cnt <= cnt + 7'd1;
  end
  assign cnt_reached = (cnt == 7'd64);

  seq_divider_64 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .cnt_reached (cnt_reached),
    .cnt_reset   (cnt_reset),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then scramble them to show they are not re-sampled.
  task automatic launch(input logic [63:0] a, input logic [63:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 64'hDEAD_BEEF_0BAD_F00D;
    divisor  = 64'h0000_0000_0000_0013;
  endtask

  // Edges after the accepting edge until done is seen (0 if it rose on that edge).
  task automatic wait_done(output int n, output logic rel);
    n   = 0;
    rel = !cnt_reset;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!cnt_reset) rel = 1'b1;
    end
  endtask

  task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er, input logic edbz,
                         input int elat, input bit full);
    int   n;
    logic rel;
    launch(a, b);
    wait_done(n, rel);
    check({tag, " latency"}, 64'(n), 64'(elat));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
    if (full) begin
      check({tag, " ready during done"}, 64'(ready), 64'd0);
      @(posedge clk); #1;
      check({tag, " done one cycle"}, 64'(done), 64'd0);
      check({tag, " ready after done"}, 64'(ready), 64'd1);
      check({tag, " quotient held"}, quotient, eq);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        rel;
    logic        saw_done;
    logic [63:0] a, b;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset cnt_reset", 64'(cnt_reset), 64'd1);
    check("reset done", 64'(done), 64'd0);
    check("reset quotient", quotient, 64'd0);
    check("reset remainder", remainder, 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: basic division and latency
    run_div("100/7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 1'b1);

    // 2: full-range dividend, then quotient zero
    run_div("max/1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65, 1'b1);
    run_div("5/9", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65, 1'b1);

    // 3: divide by zero completes on the accepting edge, counter never released
    launch(64'd123, 64'd0);
    wait_done(n, rel);
    check("div0 latency", 64'(n), 64'd0);
    check("div0 quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    check("div0 remainder", remainder, 64'd123);
    check("div0 div_by_zero", 64'(div_by_zero), 64'd1);
    @(posedge clk); #1;
    if (!cnt_reset) rel = 1'b1;
    check("div0 cnt_reset held", 64'(rel), 64'd0);
    check("div0 done one cycle", 64'(done), 64'd0);
    check("div0 ready after", 64'(ready), 64'd1);

    // A normal run after div0 clears the flag
    run_div("7/7", 64'd7, 64'd7, 64'd1, 64'd0, 1'b0, 65, 1'b0);

    // 4: start during RUN is ignored
    launch(64'd1000, 64'd3);
    repeat (19) begin @(posedge clk); #1; end
    check("busy ready", 64'(ready), 64'd0);
    check("busy cnt_reset", 64'(cnt_reset), 64'd0);
    dividend = 64'd50;
    divisor  = 64'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_done(n, rel);
    check("ignored start latency", 64'(n + 20), 64'd65);
    check("ignored start quotient", quotient, 64'd333);
    check("ignored start remainder", remainder, 64'd1);
    @(posedge clk); #1;

    // 5: reset mid-operation aborts immediately with no done
    launch(64'd1000, 64'd3);
    repeat (30) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("abort ready", 64'(ready), 64'd1);
    check("abort cnt_reset", 64'(cnt_reset), 64'd1);
    check("abort quotient", quotient, 64'd0);
    check("abort remainder", remainder, 64'd0);
    check("abort done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    check("abort no done", 64'(saw_done), 64'd0);
    run_div("9/2", 64'd9, 64'd2, 64'd4, 64'd1, 1'b0, 65, 1'b1);

    // 6: random operand pairs against a reference model
    for (int i = 0; i < 200; i++) begin
      a = {$urandom, $urandom};
      case (i % 5)
        0: b = {$urandom, $urandom};
        1: b = 64'($urandom_range(1, 1000));
        2: b = a;
        3: b = 64'h8000_0000_0000_0000;
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      if (b == 64'd0) b = 64'd1;
      run_div($sformatf("rand%0d", i), a, b, a / b, a % b, 1'b0, 65, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
